fir_filter: RTL and testbench



---
 rtl/fir_filter_pkg.sv | 20 ++
 rtl/fir_tap_mult.sv | 15 +
 rtl/fir_filter.sv | 72 +++++++
 tb/tb_fir_filter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/fir_filter_pkg.sv
// fir_filter_pkg: shared widths, coefficient table and types for fir_filter
package fir_filter_pkg;
  localparam int TAPS   = 8;
  localparam int DATA_W = 18;
  localparam int COEF_W = 18;
  localparam int FRAC_W = 17;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = 39;
  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  localparam coef_t COEF [TAPS] = '{
    18'sd4096, 18'sd8192, 18'sd16384, 18'sd32768,
    18'sd32768, 18'sd16384, 18'sd8192, 18'sd4096
  };
  localparam sample_t SMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam sample_t SMIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam acc_t ROUND = acc_t'(1) <<< (FRAC_W - 1);
endpackage

// File: rtl/fir_tap_mult.sv
// fir_tap_mult: registered signed multiply of one sample by one coefficient
module fir_tap_mult
  import fir_filter_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  sample_t x,
  input  coef_t   h,
  output prod_t   p
);
  // one product register per tap
  always_ff @(posedge clk or posedge rst)
    if (rst) p <= '0;
    else p <= x * h;
endmodule

// File: rtl/fir_filter.sv
// fir_filter: pipelined 8-tap FIR, 3-clock latency; FIR_ROUND_EN selects round-half-up
module fir_filter
  import fir_filter_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] inSignalUnReg,
  input  logic                     newData,
  output logic signed [DATA_W-1:0] outSignal,
  output logic                     dataReady
);
  sample_t in_reg;
  sample_t x [TAPS];
  prod_t   prod [TAPS];
  logic    valid0, valid1, valid2;
  acc_t    acc, rnd, shifted;
  sample_t sat;
  // input capture and valid pipeline
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      in_reg <= '0;
      valid0 <= 1'b0;
      valid1 <= 1'b0;
      valid2 <= 1'b0;
    end else begin
      in_reg <= inSignalUnReg;
      valid0 <= newData;
      valid1 <= valid0;
      valid2 <= valid1;
    end
  // delay line advances only for accepted samples
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < TAPS; i++) x[i] <= '0;
    end else if (valid0) begin
      x[0] <= in_reg;
      for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
    end
  genvar k;
  generate
    for (k = 0; k < TAPS; k++) begin : g_tap
      fir_tap_mult u_mult (
        .clk (clk),
        .rst (rst),
        .x   (x[k]),
        .h   (COEF[k]),
        .p   (prod[k])
      );
    end
  endgenerate
  // sum of products, optional rounding, shift and saturation
  always_comb begin
    acc = '0;
    for (int i = 0; i < TAPS; i++) acc = acc + acc_t'(prod[i]);
`ifdef FIR_ROUND_EN
    rnd = acc + ROUND;
`else
    rnd = acc;
`endif
    shifted = rnd >>> FRAC_W;
    sat = shifted > acc_t'(SMAX) ? SMAX : shifted < acc_t'(SMIN) ? SMIN : sample_t'(shifted);
  end
  // output register holds through bubbles
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      outSignal <= '0;
      dataReady <= 1'b0;
    end else begin
      dataReady <= valid2;
      if (valid2) outSignal <= sat;
    end
endmodule

// File: tb/tb_fir_filter.sv
// tb_fir_filter: scoreboard bench for fir_filter against a convolution model
module tb_fir_filter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [17:0] inSignalUnReg = '0;
  logic newData = 1'b0;
  logic signed [17:0] outSignal;
  logic dataReady;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_out = 0;
  int hist [$];
  int coefs [8] = '{4096, 8192, 16384, 32768, 32768, 16384, 8192, 4096};
  typedef struct {int val; int due;} exp_t;
  exp_t sbq [$];

  fir_filter dut (
    .clk           (clk),
    .rst           (rst),
    .inSignalUnReg (inSignalUnReg),
    .newData       (newData),
    .outSignal     (outSignal),
    .dataReady     (dataReady)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int model_out();
    longint s = 0;
    for (int i = 0; i < hist.size(); i++) s += longint'(hist[i]) * longint'(coefs[i]);
`ifdef FIR_ROUND_EN
    s += 65536;
`endif
    s = s >>> 17;
    if (s > 131071) s = 131071;
    if (s < -131072) s = -131072;
    return int'(s);
  endfunction

  task automatic step(input int v, input bit nd);
    exp_t e;
    inSignalUnReg = 18'(v);
    newData = nd;
    @(posedge clk);
    #1;
    if (nd && !rst) begin
      hist.push_front(v);
      if (hist.size() > 8) void'(hist.pop_back());
      e.val = model_out();
      e.due = cyc + 3;
      sbq.push_back(e);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    sbq.delete();
    hist.delete();
    last_out = 0;
    repeat (n) step(int'($urandom_range(0, 262143)) - 131072, 1'b1);
    rst = 1'b0;
  endtask

  task automatic flush();
    repeat (9) step(0, 1'b1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      total++;
      if (outSignal !== 18'sd0 || dataReady !== 1'b0) begin
        bad++;
        $display("FAIL reset: outSignal=%0d dataReady=%b required 0/0", outSignal, dataReady);
      end
    end else if (dataReady === 1'b1) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL spurious: dataReady high at cycle %0d with nothing expected", cyc);
      end else begin
        e = sbq.pop_front();
        if (int'(outSignal) != e.val || cyc != e.due) begin
          bad++;
          $display("FAIL output: got %0d at cycle %0d, required %0d at cycle %0d", outSignal, cyc, e.val, e.due);
        end
        last_out = e.val;
      end
    end else begin
      total++;
      if (int'(outSignal) != last_out || dataReady !== 1'b0) begin
        bad++;
        $display("FAIL hold: outSignal=%0d dataReady=%b required %0d/0", outSignal, dataReady, last_out);
      end
    end
  end

  initial begin
    do_reset(3);
    step(0, 1'b1);
    flush();
    step(65536, 1'b1);
    flush();
    repeat (12) step(65536, 1'b1);
    flush();
    step(65536, 1'b1);
    for (int i = 0; i < 9; i++) begin
      step(0, 1'b0);
      step(0, 1'b1);
    end
    step(0, 1'b0);
    step(0, 1'b0);
    flush();
    step(131071, 1'b1);
    flush();
    step(-65536, 1'b1);
    flush();
    repeat (5) step(65536, 1'b1);
    #1;
    rst = 1'b1;
    sbq.delete();
    hist.delete();
    last_out = 0;
    #1;
    total++;
    if (outSignal !== 18'sd0 || dataReady !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: outSignal=%0d dataReady=%b required 0/0", outSignal, dataReady);
    end
    do_reset(2);
    repeat (10) step(65536, 1'b1);
    flush();
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 3));
      step(r == 0 ? 131071 : r == 1 ? -131072 : int'($urandom_range(0, 262143)) - 131072, 1'($urandom_range(0, 3) != 0));
    end
    repeat (6) step(0, 1'b0);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d outputs still pending, required 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
